// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants for the multiply/divide sequencer
//   state encoding, unit_op codes, rstatus register and exception status codes
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic [4:0]  RSTATUS_REG     = 5'd30;
  localparam logic [31:0] STATUS_MULT_OVF = 32'd4;
  localparam logic [31:0] STATUS_DIV_ERR  = 32'd5;

endpackage

// File: rtl/multdiv_counter.sv
// rtl/multdiv_counter.sv - loadable down-counter with zero flag for iteration tracking
//   clock, reset : clock and asynchronous active-high reset
//   load/load_val: load a new count (takes priority over dec)
//   dec          : decrement by one, saturating at zero
//   zero         : count is zero
module multdiv_counter
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequencer for an external iterative multiply/divide unit
//   inputs : clock, reset (async, active-high), ctrl_mult, ctrl_div, in_rd, flush,
//            unit_exception
//   outputs: unit_start, unit_op, unit_step (unit control), stall, busy (pipeline),
//            wb_en, wb_reg, wb_sel_status, status_code (register-file writeback)
//   MULTDIV_EXCEPTION_EN: when defined, an exception in DONE redirects the
//   writeback to rstatus (r30) with a status code; otherwise unit_exception is ignored.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic        ctrl_div,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  input  logic        unit_exception,
  output logic        unit_start,
  output logic        unit_op,
  output logic        unit_step,
  output logic        stall,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic        wb_sel_status,
  output logic [31:0] status_code
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e     state_q;
  logic [4:0] rd_q;
  logic       op_q;

  logic       in_idle;
  logic       in_run;
  logic       in_done;
  logic       accept;
  logic       req_op;
  logic       cnt_zero;
  logic [4:0] done_reg;

  assign in_idle = (state_q == ST_IDLE);
  assign in_run  = (state_q == ST_RUN);
  assign in_done = (state_q == ST_DONE);

  // Multiply has priority when both requests are raised together.
  assign req_op = ctrl_mult ? OP_MULT : OP_DIV;

  // Gating with reset keeps every output low while reset is held.
  assign accept = in_idle & (ctrl_mult | ctrl_div) & ~flush & ~reset;

  // Counter is loaded with N-1 in the accept cycle so RUN spans exactly N cycles.
  multdiv_counter u_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (ctrl_mult ? MULT_LOAD : DIV_LOAD),
    .dec      (in_run),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      op_q    <= OP_MULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_RUN;
            rd_q    <= in_rd;
            op_q    <= req_op;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (cnt_zero) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign unit_start = accept;
  assign unit_op    = accept ? req_op : (in_idle ? OP_MULT : op_q);
  assign unit_step  = in_run;
  assign stall      = accept | in_run;
  assign busy       = ~in_idle;

`ifdef MULTDIV_EXCEPTION_EN
  logic exc_hit;
  assign exc_hit       = in_done & unit_exception;
  assign done_reg      = exc_hit ? RSTATUS_REG : rd_q;
  assign wb_sel_status = exc_hit;
  assign status_code   = exc_hit ? ((op_q == OP_DIV) ? STATUS_DIV_ERR : STATUS_MULT_OVF) : '0;
`else
  logic unused_exception;
  assign unused_exception = unit_exception;
  assign done_reg         = rd_q;
  assign wb_sel_status    = 1'b0;
  assign status_code      = '0;
`endif

  assign wb_reg = in_done ? done_reg : '0;
  // r0 is hardwired, so a write to it is dropped; flush cancels the write too.
  assign wb_en  = in_done & ~flush & (done_reg != '0);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - self-checking bench for multdiv_ctrl
module tb_multdiv_ctrl;

  localparam int MC = 32;
  localparam int DC = 32;

`ifdef MULTDIV_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic        flush = 1'b0;
  logic        unit_exception = 1'b0;
  logic        unit_start, unit_op, unit_step, stall, busy, wb_en, wb_sel_status;
  logic [4:0]  wb_reg;
  logic [31:0] status_code;

  int total = 0;
  int bad = 0;

  multdiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .in_rd          (in_rd),
    .flush          (flush),
    .unit_exception (unit_exception),
    .unit_start     (unit_start),
    .unit_op        (unit_op),
    .unit_step      (unit_step),
    .stall          (stall),
    .busy           (busy),
    .wb_en          (wb_en),
    .wb_reg         (wb_reg),
    .wb_sel_status  (wb_sel_status),
    .status_code    (status_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctl"}, {20'd0, unit_start, unit_op, unit_step, stall, busy, wb_en, wb_sel_status, wb_reg}, 32'd0);
    chk({name, "_status"}, status_code, 32'd0);
  endtask

  // ---------------- table-driven single-request vectors ----------------
  typedef struct {
    logic       m;
    logic       d;
    logic [4:0] rd;
    int         flush_at;   // cycle offset from request where flush is raised, -1 none
    logic       exp_op;
    int         exp_stall;
    int         exp_step;
    int         exp_start;
    int         exp_wb;
    int         exp_done;   // offset of the DONE cycle, -1 if never reached
    logic [4:0] exp_reg;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx, input vec_t v);
    int n_stall = 0, n_step = 0, n_start = 0, n_wb = 0, done_off = -1;
    logic [4:0] done_reg = 5'd0;
    logic op_t = 1'b0;
    string p;
    p = $sformatf("vec%0d", idx);
    ctrl_mult = v.m;
    ctrl_div  = v.d;
    in_rd     = v.rd;
    for (int c = 0; c < 40; c++) begin
      flush = (c == v.flush_at);
      @(negedge clock);
      if (c == 0) op_t = unit_op;
      n_stall += int'(stall);
      n_step  += int'(unit_step);
      n_start += int'(unit_start);
      n_wb    += int'(wb_en);
      if (busy && !stall && done_off < 0) begin
        done_off = c;
        done_reg = wb_reg;
      end
      if (v.flush_at > 0 && c == v.flush_at + 1) begin
        chk({p, "_flush_busy"}, {31'd0, busy}, 32'd0);
        chk({p, "_flush_stall"}, {31'd0, stall}, 32'd0);
      end
      @(posedge clock);
      #1;
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      in_rd     = 5'h1f;
    end
    flush = 1'b0;
    in_rd = 5'd0;
    chk({p, "_op"}, {31'd0, op_t}, {31'd0, v.exp_op});
    chk({p, "_stall_cycles"}, n_stall, v.exp_stall);
    chk({p, "_step_cycles"}, n_step, v.exp_step);
    chk({p, "_start_pulses"}, n_start, v.exp_start);
    chk({p, "_wb_pulses"}, n_wb, v.exp_wb);
    chk({p, "_done_offset"}, done_off, v.exp_done);
    chk({p, "_wb_reg"}, {27'd0, done_reg}, {27'd0, v.exp_reg});
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks one accepted request by its start cycle and derives every output
  // from the elapsed cycle count.
  bit         m_active = 1'b0;
  int         m_t0 = 0;
  int         m_n = 0;
  logic       m_op = 1'b0;
  logic [4:0] m_rd = 5'd0;

  task automatic model_eval(input int cyc, output logic [31:0] ctl, output logic [31:0] st);
    logic e_start = 0, e_op = 0, e_step = 0, e_stall = 0, e_busy = 0, e_wb = 0, e_sel = 0;
    logic [4:0] e_reg = 0;
    int k;
    st = 32'd0;
    if (!m_active) begin
      if ((ctrl_mult || ctrl_div) && !flush) begin
        e_start  = 1;
        e_stall  = 1;
        e_op     = ctrl_mult ? 1'b0 : 1'b1;
        m_active = 1;
        m_t0     = cyc;
        m_op     = e_op;
        m_rd     = in_rd;
        m_n      = ctrl_mult ? MC : DC;
      end
    end else begin
      k      = cyc - m_t0;
      e_busy = 1;
      e_op   = m_op;
      if (k <= m_n) begin
        e_step  = 1;
        e_stall = 1;
      end else begin
        if (EXC_EN && unit_exception) begin
          e_reg = 5'd30;
          e_sel = 1;
          st    = m_op ? 32'd5 : 32'd4;
        end else begin
          e_reg = m_rd;
        end
        e_wb = !flush && (e_reg != 0);
      end
      if (flush || k > m_n) m_active = 0;
    end
    ctl = {20'd0, e_start, e_op, e_step, e_stall, e_busy, e_wb, e_sel, e_reg};
  endtask

  initial begin
    logic [31:0] exp_ctl, exp_st;
    int done_off;

    vecs[0] = '{1'b1, 1'b0, 5'd7,  -1, 1'b0, 33, 32, 1, 1, 33, 5'd7};
    vecs[1] = '{1'b1, 1'b1, 5'd3,  -1, 1'b0, 33, 32, 1, 1, 33, 5'd3};
    vecs[2] = '{1'b0, 1'b1, 5'd11, -1, 1'b1, 33, 32, 1, 1, 33, 5'd11};
    vecs[3] = '{1'b1, 1'b0, 5'd9,  10, 1'b0, 11, 10, 1, 0, -1, 5'd0};
    vecs[4] = '{1'b1, 1'b0, 5'd0,  -1, 1'b0, 33, 32, 1, 0, 33, 5'd0};
    vecs[5] = '{1'b0, 1'b1, 5'd4,   0, 1'b0, 0,  0,  0, 0, -1, 5'd0};
    vecs[6] = '{1'b0, 1'b1, 5'd12, 33, 1'b1, 33, 32, 1, 0, 33, 5'd12};

    // reset state, with a request present while reset is held
    ctrl_mult = 1'b1;
    in_rd = 5'd9;
    #2;
    check_all_zero("reset_hold");
    @(posedge clock);
    #1;
    reset = 1'b0;
    ctrl_mult = 1'b0;
    in_rd = 5'd0;
    @(negedge clock);
    check_all_zero("idle_no_req");
    @(posedge clock);
    #1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // exception handling in DONE for both ops
    for (int op = 0; op < 2; op++) begin
      ctrl_mult = (op == 0);
      ctrl_div  = (op == 1);
      in_rd     = 5'd11;
      unit_exception = 1'b1;
      done_off = -1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        if (busy && !stall && done_off < 0) begin
          done_off = c;
          chk($sformatf("exc%0d_wb_reg", op), {27'd0, wb_reg}, EXC_EN ? 32'd30 : 32'd11);
          chk($sformatf("exc%0d_sel", op), {31'd0, wb_sel_status}, {31'd0, EXC_EN});
          chk($sformatf("exc%0d_status", op), status_code, EXC_EN ? (op == 1 ? 32'd5 : 32'd4) : 32'd0);
          chk($sformatf("exc%0d_wb_en", op), {31'd0, wb_en}, 32'd1);
        end
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
      end
      unit_exception = 1'b0;
      chk($sformatf("exc%0d_done_offset", op), done_off, 32'd33);
    end

    // asynchronous reset in the middle of RUN, then a fresh divide
    ctrl_mult = 1'b1;
    in_rd = 5'd6;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    repeat (14) @(posedge clock);
    #2;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    check_all_zero("reset_held_edge");
    @(posedge clock);
    #1;
    reset = 1'b0;
    ctrl_div = 1'b1;
    in_rd = 5'd5;
    done_off = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (c == 0) chk("post_reset_start", {31'd0, unit_start}, 32'd1);
      if (wb_en) begin
        if (done_off < 0) done_off = c;
        chk("post_reset_wb_reg", {27'd0, wb_reg}, 32'd5);
      end
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
      in_rd = 5'd0;
    end
    chk("post_reset_wb_offset", done_off, 32'd33);

    // randomized traffic against the reference model
    m_active = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ctrl_mult      = ($urandom_range(0, 7) == 0);
      ctrl_div       = ($urandom_range(0, 5) == 0);
      in_rd          = 5'($urandom);
      flush          = ($urandom_range(0, 29) == 0);
      unit_exception = 1'($urandom_range(0, 1));
      @(negedge clock);
      model_eval(i, exp_ctl, exp_st);
      chk($sformatf("rand%0d_ctl", i),
          {20'd0, unit_start, unit_op, unit_step, stall, busy, wb_en, wb_sel_status, wb_reg}, exp_ctl);
      chk($sformatf("rand%0d_status", i), status_code, exp_st);
      @(posedge clock);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
